fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of the byte-addressed instruction memory, which returns a combinational, big-endian 32-bit word. Owns the program counter and drives the memory address. Captures each returned word with its PC into a small FIFO, and presents it to the decoder over a valid/ready handshake. Accepts branch/jump redirects from execute, which flush all queued fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
DEPTH, 2, fetch FIFO entries; power of two, >= 2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
imem_addr  output  32  byte address to instruction memory; equals pc register.
imem_inst  input  32  instruction word returned combinationally for imem_addr.
redirect  input  1  taken branch/jump from execute; one-cycle pulse.
redirect_pc  input  32  target byte address; valid when redirect=1.
out_valid  output  1  head entry available for decoder.
out_ready  input  1  decoder accepts head entry this cycle.
out_inst  output  32  head instruction; 32'h0000_0013 (NOP) when FIFO empty.
out_pc  output  32  PC of head instruction; 0 when FIFO empty.
misalign_err  output  1  sticky flag, set when redirect_pc[1:0] != 0.

Behaviour:
- Reset, asynchronous, active-high:
  - pc=RESET_PC; FIFO count, read pointer and write pointer = 0; misalign_err=0.
  - Outputs during reset: out_valid=0, out_inst=32'h13, out_pc=0, imem_addr=RESET_PC.
  - Reset asserted mid-operation discards all queued entries immediately.
- Handshake signals, both combinational:
  - out_valid = (count != 0) && !redirect.
  - pop = out_valid && out_ready.
- Push: push = !redirect && (count < DEPTH || pop).
  - On push, write {pc, imem_inst} at the write pointer and set pc <= pc + 4.
  - pc wraps modulo 2^32 with no error.
- Full FIFO without pop: no push; pc holds; imem_addr stable.
- Simultaneous push and pop: count unchanged; both pointers advance modulo DEPTH.
- Redirect has priority over push and pop in the same cycle:
  - count <= 0; pointers <= 0.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - out_valid is forced 0 in the redirect cycle, so no handshake occurs.
  - The word fetched in the redirect cycle is discarded.
- Misalignment: if redirect && redirect_pc[1:0] != 0, set misalign_err to 1. It stays 1 until reset; the redirect itself still proceeds with the low bits cleared.
- Latency:
  - The word at address A is pushed on the edge ending the cycle in which pc==A.
  - It appears at out_* in the next cycle, i.e. 1-cycle fetch-to-decode latency.
  - First instruction after reset release: out_valid=1 on the cycle after the first rising edge.
- Sustained throughput is 1 instruction/cycle when out_ready is held 1.
- Entries leave in fetch order; out_pc of consecutive entries differs by +4 except across a redirect.
- No combinational path from imem_inst to any output; out_* come only from FIFO storage.

Test Plan:
- Reset release, out_ready=1, memory bytes 00 10 03 13 / 00 63 03 33 / 3f e3 03 13 at addresses 0/4/8 -> on consecutive cycles out_valid=1 with (out_pc, out_inst) = (0, 0x00100313), (4, 0x00630333), (8, 0x3fe30313).
- out_ready=0 from reset -> two pushes, then count=2 and imem_addr holds at 8. Raise out_ready -> out_pc sequence 0, 4, 8 with no gaps or duplicates.
- Steady stream, then redirect=1 with redirect_pc=0x40 at the cycle out_pc=0x8 -> out_valid=0 that cycle, and nothing is popped even though out_ready=1. Next cycle imem_addr=0x40; the cycle after that out_pc=0x40, out_inst=0x00002e03. Entries at 0xC/0x10 are never presented.
- redirect_pc=0x42 -> misalign_err=1 and pc=0x40. Further aligned redirects leave misalign_err=1; only rst clears it.
- Assert rst asynchronously mid-stream between clock edges with FIFO full -> out_valid drops to 0 immediately and imem_addr=RESET_PC; after release, fetch restarts at RESET_PC.
- Random out_ready at 50% over 1000 cycles -> every accepted out_pc equals previous +4, and count never exceeds DEPTH.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, redirect input from execute,
// and the valid/ready handshake towards the decoder.
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        misalign_err;

    modport master (
        output imem_addr,
        output out_valid,
        output out_inst,
        output out_pc,
        output misalign_err,
        input  imem_inst,
        input  redirect,
        input  redirect_pc,
        input  out_ready
    );

    modport slave (
        input  imem_addr,
        input  out_valid,
        input  out_inst,
        input  out_pc,
        input  misalign_err,
        output imem_inst,
        output redirect,
        output redirect_pc,
        output out_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, queues fetched {pc, inst} pairs in a
// small FIFO for the decoder, and flushes the queue on execute redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    localparam int          PW  = $clog2(DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          misalign;

    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];

    logic          not_empty;
    logic          has_room;
    logic          valid;
    logic          push;
    logic          pop;

    // Redirect masks the head so no handshake can retire a flushed entry.
    assign not_empty = (count != '0);
    assign has_room  = (count < CW'(DEPTH));
    assign valid     = not_empty && !bus.redirect;
    assign pop       = valid && bus.out_ready;
    assign push      = !bus.redirect && (has_room || pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            misalign <= 1'b0;
        end else if (bus.redirect) begin
            pc     <= {bus.redirect_pc[31:2], 2'b00};
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                misalign <= 1'b1;
            end
        end else begin
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // NOTE: FIFO storage carries no reset; the count gates every read, so stale
    // contents are never observed and the arrays can map onto plain registers/RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= pc;
            mem_inst[wr_ptr] <= bus.imem_inst;
        end
    end

    // Outputs come only from stored state, never straight from imem_inst.
    assign bus.imem_addr    = pc;
    assign bus.out_valid    = valid;
    assign bus.out_inst     = not_empty ? mem_inst[rd_ptr] : NOP;
    assign bus.out_pc       = not_empty ? mem_pc[rd_ptr] : 32'h0000_0000;
    assign bus.misalign_err = misalign;
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: expected fetch stream is
// generated from a sequential-PC model and compared on every accepted handshake.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    entry_t      exp_q[$];
    logic [31:0] model_next;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0010_0313;
            32'h0000_0004: return 32'h0063_0333;
            32'h0000_0008: return 32'h3fe3_0313;
            32'h0000_0040: return 32'h0000_2e03;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
        endcase
    endfunction

    assign bus.imem_inst = mem_word(bus.imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the decoder sees consecutive word addresses, restarting
    // from the aligned target on every redirect or reset.
    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: model_next, inst: mem_word(model_next)});
            model_next = model_next + 32'd4;
        end
    endtask

    task automatic model_restart(input logic [31:0] a);
        exp_q.delete();
        model_next = {a[31:2], 2'b00};
        topup();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        topup();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.redirect = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_restart(RESET_PC);
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        bus.redirect    = 1'b1;
        bus.redirect_pc = tgt;
        model_restart(tgt);
    endtask

    // Monitor: compares each accepted entry against the model queue.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            logic [31:0] occ;
            occ = (bus.imem_addr - bus.out_pc) >> 2;
            check("fifo occupancy in range", {31'b0, (occ >= 1 && occ <= DEPTH)}, 32'd1);
            if (bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected entry", bus.out_pc, 32'hxxxx_xxxx);
                end else begin
                    entry_t e;
                    e = exp_q.pop_front();
                    check("stream out_pc", bus.out_pc, e.pc);
                    check("stream out_inst", bus.out_inst, e.inst);
                end
                pops++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.out_ready   = 1'b1;
        model_next      = RESET_PC;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset out_inst", bus.out_inst, 32'h0000_0013);
        check("reset out_pc", bus.out_pc, 32'h0);
        check("reset imem_addr", bus.imem_addr, RESET_PC);
        check("reset misalign", {31'b0, bus.misalign_err}, 32'd0);

        // First three instructions on consecutive cycles
        bus.out_ready = 1'b1;
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            logic [31:0] a;
            tick();
            a = 32'(4 * k);
            check("first valid", {31'b0, bus.out_valid}, 32'd1);
            check("first out_pc", bus.out_pc, a);
            check("first out_inst", bus.out_inst, mem_word(a));
        end

        // Back-pressure: FIFO fills, PC holds
        bus.out_ready = 1'b0;
        reset_dut();
        tick();
        check("bp imem_addr 1", bus.imem_addr, 32'h4);
        tick();
        check("bp imem_addr 2", bus.imem_addr, 32'h8);
        check("bp head pc", bus.out_pc, 32'h0);
        tick();
        check("bp imem_addr hold", bus.imem_addr, 32'h8);
        bus.out_ready = 1'b1;
        tick();
        check("bp resume pc 4", bus.out_pc, 32'h4);
        tick();
        check("bp resume pc 8", bus.out_pc, 32'h8);
        tick();

        // Redirect while out_pc == 8
        reset_dut();
        tick();
        tick();
        tick();
        do_redirect(32'h0000_0040);
        #1;
        check("redir out_valid forced 0", {31'b0, bus.out_valid}, 32'd0);
        check("redir head still 8", bus.out_pc, 32'h8);
        tick();
        bus.redirect = 1'b0;
        check("redir imem_addr", bus.imem_addr, 32'h40);
        check("redir empty", {31'b0, bus.out_valid}, 32'd0);
        tick();
        check("redir target valid", {31'b0, bus.out_valid}, 32'd1);
        check("redir target pc", bus.out_pc, 32'h40);
        check("redir target inst", bus.out_inst, 32'h0000_2e03);
        tick();

        // Misaligned redirect, sticky flag
        check("misalign clear before", {31'b0, bus.misalign_err}, 32'd0);
        do_redirect(32'h0000_0042);
        tick();
        bus.redirect = 1'b0;
        check("misalign set", {31'b0, bus.misalign_err}, 32'd1);
        check("misalign pc aligned", bus.imem_addr, 32'h40);
        tick();
        tick();
        do_redirect(32'h0000_0080);
        tick();
        bus.redirect = 1'b0;
        check("misalign sticky", {31'b0, bus.misalign_err}, 32'd1);
        check("aligned redirect pc", bus.imem_addr, 32'h80);

        // PC wrap at 2^32
        tick();
        do_redirect(32'hFFFF_FFF8);
        tick();
        bus.redirect = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // Asynchronous reset mid-cycle with a full FIFO
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("full before async rst", {31'b0, bus.out_valid}, 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("async rst out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("async rst imem_addr", bus.imem_addr, RESET_PC);
        check("async rst out_inst", bus.out_inst, 32'h0000_0013);
        check("async rst misalign", {31'b0, bus.misalign_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        model_restart(RESET_PC);
        tick();
        check("restart valid", {31'b0, bus.out_valid}, 32'd1);
        check("restart pc", bus.out_pc, RESET_PC);

        // Random back-pressure and redirects
        for (int i = 0; i < 1000; i++) begin
            tick();
            bus.out_ready = 1'($urandom % 2);
            if ($urandom_range(31) == 0) begin
                logic [31:0] tgt;
                tgt = $urandom;
                if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
                do_redirect(tgt);
            end else begin
                bus.redirect = 1'b0;
            end
        end
        tick();
        bus.redirect = 1'b0;
        tick();

        check("handshake activity", {31'b0, (pops > 300)}, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
